// File: rtl/bcd_to_bin.sv
// Multi-cycle packed-BCD to binary converter.
// Folds one BCD digit per clock, most significant digit first.
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [BIN_W-1:0]      r_acc;
    logic [IDX_W-1:0]      r_idx;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [BIN_W-1:0]      r_bin;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    state_t                w_state;
    logic [BIN_W-1:0]      w_acc;
    logic [IDX_W-1:0]      w_idx;
    logic [4*DIGITS-1:0]   w_bcd;
    logic [BIN_W-1:0]      w_bin;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_err;
    logic                  w_bad;
    logic [3:0]            w_digit;
    logic [BIN_W-1:0]      w_acc_mul;

    always_comb begin
        w_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_in[4*k +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    // acc*10 + digit, built from shifts so it stays BIN_W wide
    assign w_digit   = r_bcd[{r_idx, 2'b00} +: 4];
    assign w_acc_mul = {r_acc[BIN_W-4:0], 3'b000}
                     + {r_acc[BIN_W-2:0], 1'b0}
                     + {{(BIN_W-4){1'b0}}, w_digit};

    always_comb begin
        w_state = r_state;
        w_acc   = r_acc;
        w_idx   = r_idx;
        w_bcd   = r_bcd;
        w_bin   = r_bin;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_err   = r_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_bad) begin
                        w_bin   = '0;
                        w_err   = 1'b1;
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_state = S_DONE;
                    end else begin
                        w_bcd   = bcd_in;
                        w_acc   = '0;
                        w_idx   = IDX_TOP;
                        w_err   = 1'b0;
                        w_busy  = 1'b1;
                        w_state = S_CONV;
                    end
                end
            end
            S_CONV: begin
                w_acc = w_acc_mul;
                if (r_idx == '0) begin
                    w_bin   = w_acc_mul;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_idx   = IDX_TOP;
                    w_state = S_DONE;
                end else begin
                    w_idx = r_idx - IDX_W'(1);
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_idx   <= IDX_TOP;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_acc   <= w_acc;
            r_idx   <= w_idx;
            r_bcd   <= w_bcd;
            r_bin   <= w_bin;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    assign bin  = r_bin;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin.
// Each scenario task drives stimulus and checks inline.
module tb_bcd_to_bin;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        err;

    int n_pass = 0;
    int n_total = 0;
    int overlap = 0;

    bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .bcd_in (bcd_in),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (busy && done) overlap++;
    endtask

    // Runs from the sampling edge until done; edges=99 on timeout.
    task automatic wait_done(input logic hold, input logic [15:0] bcd_after,
                             output int edges, output int busyc,
                             output logic err1);
        edges = 0;
        busyc = 0;
        err1  = 1'bx;
        for (int i = 0; i < 12; i++) begin
            step();
            edges++;
            if (edges == 1) begin
                err1 = err;
                if (!hold) start = 1'b0;
                else bcd_in = bcd_after;
            end
            if (busy) busyc++;
            if (done) return;
        end
        edges = 99;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        #12;
        n_total++;
        if (bin !== 14'd0) $display("FAIL reset_bin got %0d want 0", bin);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else n_pass++;
        n_total++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err);
        else n_pass++;
        step();
        clr = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int e, b;
        logic e1;
        bcd_in = 16'h1234;
        start  = 1'b1;
        wait_done(1'b0, 16'h0, e, b, e1);
        n_total++;
        if (e !== 5) $display("FAIL basic_latency got %0d want 5", e);
        else n_pass++;
        n_total++;
        if (b !== 4) $display("FAIL basic_busy_cycles got %0d want 4", b);
        else n_pass++;
        n_total++;
        if (bin !== 14'd1234) $display("FAIL basic_bin got %0d want 1234", bin);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL basic_err got %b want 0", err);
        else n_pass++;
        step();
        n_total++;
        if (done !== 1'b0) $display("FAIL basic_done_width got %b want 0", done);
        else n_pass++;
        step();
    endtask

    task automatic test_max_zero();
        int e, b;
        logic e1;
        bcd_in = 16'h9999;
        start  = 1'b1;
        wait_done(1'b0, 16'h0, e, b, e1);
        n_total++;
        if (e !== 5 || bin !== 14'h270F)
            $display("FAIL max_bin got %0d@%0d want 9999@5", bin, e);
        else n_pass++;
        step();
        step();
        bcd_in = 16'h0000;
        start  = 1'b1;
        wait_done(1'b0, 16'h0, e, b, e1);
        n_total++;
        if (e !== 5 || bin !== 14'd0 || err !== 1'b0)
            $display("FAIL zero_bin got %0d@%0d err %b want 0@5 err 0",
                     bin, e, err);
        else n_pass++;
        step();
        step();
    endtask

    task automatic test_invalid();
        int e, b;
        logic e1;
        bcd_in = 16'h12A4;
        start  = 1'b1;
        step();
        start = 1'b0;
        n_total++;
        if (done !== 1'b1 || err !== 1'b1 || bin !== 14'd0 || busy !== 1'b0)
            $display("FAIL invalid_first got d%b e%b bin%0d b%b want d1 e1 bin0 b0",
                     done, err, bin, busy);
        else n_pass++;
        step();
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1)
            $display("FAIL invalid_after got d%b b%b e%b want d0 b0 e1",
                     done, busy, err);
        else n_pass++;
        bcd_in = 16'h0042;
        start  = 1'b1;
        wait_done(1'b0, 16'h0, e, b, e1);
        n_total++;
        if (e1 !== 1'b0) $display("FAIL invalid_err_clear got %b want 0", e1);
        else n_pass++;
        n_total++;
        if (e !== 5 || bin !== 14'd42)
            $display("FAIL invalid_next_bin got %0d@%0d want 42@5", bin, e);
        else n_pass++;
        step();
        step();
    endtask

    task automatic test_start_during_conv();
        int e, b, extra;
        logic e1;
        bcd_in = 16'h0567;
        start  = 1'b1;
        wait_done(1'b1, 16'h8888, e, b, e1);
        start = 1'b0;
        n_total++;
        if (e !== 5 || bin !== 14'd567)
            $display("FAIL conv_ignore_bin got %0d@%0d want 567@5", bin, e);
        else n_pass++;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) extra++;
        end
        n_total++;
        if (extra !== 0) $display("FAIL conv_no_requeue got %0d want 0", extra);
        else n_pass++;
        n_total++;
        if (bin !== 14'd567) $display("FAIL conv_bin_hold got %0d want 567", bin);
        else n_pass++;
    endtask

    task automatic test_clr_mid();
        int e, b, seen;
        logic e1;
        bcd_in = 16'h4321;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        #2;
        clr = 1'b0;
        #1;
        n_total++;
        if (bin !== 14'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
            $display("FAIL clr_async got bin%0d b%b d%b e%b want all 0",
                     bin, busy, done, err);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) seen++;
        end
        #2;
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            if (done) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL clr_no_done got %0d want 0", seen);
        else n_pass++;
        bcd_in = 16'h0007;
        start  = 1'b1;
        wait_done(1'b0, 16'h0, e, b, e1);
        n_total++;
        if (e !== 5 || bin !== 14'd7)
            $display("FAIL clr_restart got %0d@%0d want 7@5", bin, e);
        else n_pass++;
        step();
        step();
    endtask

    task automatic test_back_to_back();
        int pulses;
        int pos[4];
        logic [13:0] val[4];
        bcd_in = 16'h0010;
        start  = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (done) begin
                if (pulses < 4) begin
                    pos[pulses] = i;
                    val[pulses] = bin;
                end
                pulses++;
            end
        end
        start = 1'b0;
        n_total++;
        if (pulses !== 2) $display("FAIL b2b_pulses got %0d want 2", pulses);
        else n_pass++;
        if (pulses == 2) begin
            n_total++;
            if (pos[0] !== 5 || pos[1] !== 11)
                $display("FAIL b2b_spacing got %0d,%0d want 5,11", pos[0], pos[1]);
            else n_pass++;
            n_total++;
            if (val[0] !== 14'd10 || val[1] !== 14'd10)
                $display("FAIL b2b_bin got %0d,%0d want 10,10", val[0], val[1]);
            else n_pass++;
        end
        for (int i = 0; i < 10; i++) step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_zero();
        test_invalid();
        test_start_during_conv();
        test_clr_mid();
        test_back_to_back();
        n_total++;
        if (overlap !== 0) $display("FAIL busy_done_overlap got %0d want 0", overlap);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
